// File: rtl/y86_inst_loader_pkg.sv
// Shared types and Y86-64 instruction codes for the instruction loader.
package y86_inst_loader_pkg;

    // Y86-64 instruction codes, matching the fetch stage's decoding.
    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    typedef enum logic {
        IDLE,
        EMIT
    } loaderState;

    // One decoded instruction as presented on the loader's input.
    typedef struct packed {
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  rA;
        logic [3:0]  rB;
        logic [63:0] valC;
    } instFields;

endpackage

// File: rtl/y86_inst_loader_if.sv
// Instruction handshake and byte-wide memory write bus of the loader.
interface y86_inst_loader_if #(
    parameter int ADDR_W = 64
);
    logic              restart_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [3:0]        icode_i;
    logic [3:0]        ifun_i;
    logic [3:0]        rA_i;
    logic [3:0]        rB_i;
    logic [63:0]       valC_i;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [7:0]        mem_wdata_o;
    logic [ADDR_W-1:0] wr_ptr_o;
    logic [15:0]       inst_count_o;
    logic              busy_o;
    logic              err_o;

    // Instruction producer / memory observer side.
    modport master (
        output restart_i, in_valid_i, icode_i, ifun_i, rA_i, rB_i, valC_i,
        input  in_ready_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  wr_ptr_o, inst_count_o, busy_o, err_o
    );

    // Loader side.
    modport slave (
        input  restart_i, in_valid_i, icode_i, ifun_i, rA_i, rB_i, valC_i,
        output in_ready_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output wr_ptr_o, inst_count_o, busy_o, err_o
    );
endinterface

// File: rtl/y86_inst_loader_len.sv
// Y86-64 instruction length decoder: icode -> byte length, 0 for an invalid code.
module y86_inst_len
    import y86_inst_loader_pkg::*;
(
    input  logic [3:0] icode,
    output logic [3:0] instLen
);

    // Length lookup by instruction class.
    always_comb begin
        // NOTE: default assignment first so every path drives instLen and no latch is inferred.
        instLen = 4'd0;
        case (icode)
            IHALT, INOP, IRET:             instLen = 4'd1;
            IRRMOVQ, IOPQ, IPUSHQ, IPOPQ:  instLen = 4'd2;
            IJXX, ICALL:                   instLen = 4'd9;
            IIRMOVQ, IRMMOVQ, IMRMOVQ:     instLen = 4'd10;
            default:                       instLen = 4'd0;
        endcase
    end

endmodule

// File: rtl/y86_inst_loader.sv
// Byte-serial Y86-64 instruction encoder writing one byte per cycle into program RAM.
module y86_inst_loader
    import y86_inst_loader_pkg::*;
#(
    parameter int                MEM_SIZE  = 1024,
    parameter int                ADDR_W    = 64,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input logic              clk_i,
    input logic              rst_i,
    y86_inst_loader_if.slave bus
);

    loaderState        state, nextState;
    instFields         inFields, instQ, selInst;
    logic [3:0]        newLen, lenQ, selLen;
    logic [3:0]        byteIdx, idxD, selIdx;
    logic [2:0]        valOff;
    logic [7:0]        byteMux;
    logic [ADDR_W:0]   endSum;
    logic              fits, accept, take, rejectNow, lastByte;

    logic              weQ, readyQ, busyQ, errQ;
    logic              weD, readyD, busyD, errD;
    logic [ADDR_W-1:0] addrQ, ptrQ, addrD, ptrD;
    logic [7:0]        dataQ, dataD;
    logic [15:0]       countQ, countD;

    y86_inst_len u_len (
        .icode   (bus.icode_i),
        .instLen (newLen)
    );

    assign inFields  = {bus.icode_i, bus.ifun_i, bus.rA_i, bus.rB_i, bus.valC_i};
    // The end address needs one extra bit so a pointer near the top cannot wrap past the check.
    assign endSum    = {1'b0, ptrQ} + (ADDR_W+1)'(newLen);
    assign fits      = (newLen != 4'd0) && (endSum <= (ADDR_W+1)'(MEM_SIZE));
    assign accept    = bus.in_valid_i & readyQ;
    assign take      = accept & fits & ~bus.restart_i;
    assign rejectNow = accept & ~fits & ~bus.restart_i;
    assign lastByte  = (state == EMIT) && (byteIdx == 4'(lenQ - 4'd1));

    // State register.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (rst_i) state <= IDLE;
        else       state <= nextState;
    end

    // Next-state logic; restart abandons any emission.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (take) nextState = EMIT;
            EMIT:    if (lastByte) nextState = IDLE;
            default: nextState = IDLE;
        endcase
        if (bus.restart_i) nextState = IDLE;
    end

    // Byte mux: byte 0 comes straight from the inputs on accept, later bytes from the latched fields.
    always_comb begin
        selInst = (state == IDLE) ? inFields : instQ;
        selLen  = (state == IDLE) ? newLen : lenQ;
        selIdx  = (state == IDLE) ? 4'd0 : 4'(byteIdx + 4'd1);
        valOff  = 3'(selIdx - ((selLen == 4'd10) ? 4'd2 : 4'd1));
        if (selIdx == 4'd0)
            byteMux = {selInst.icode, selInst.ifun};
        else if (selIdx == 4'd1 && selLen != 4'd9)
            byteMux = {selInst.rA, selInst.rB};
        else
            byteMux = 8'(selInst.valC >> {valOff, 3'b000});
    end

    // Output logic: next values of the registered outputs.
    always_comb begin
        weD    = 1'b0;
        addrD  = addrQ;
        dataD  = dataQ;
        readyD = readyQ;
        busyD  = busyQ;
        errD   = 1'b0;
        ptrD   = ptrQ;
        countD = countQ;
        idxD   = byteIdx;
        if (bus.restart_i) begin
            readyD = 1'b1;
            busyD  = 1'b0;
            ptrD   = BASE_ADDR;
            countD = 16'd0;
        end else if (state == IDLE) begin
            if (take) begin
                weD    = 1'b1;
                addrD  = ptrQ;
                dataD  = byteMux;
                readyD = 1'b0;
                busyD  = 1'b1;
                idxD   = 4'd0;
            end else if (rejectNow) begin
                errD = 1'b1;
            end
        end else if (lastByte) begin
            readyD = 1'b1;
            busyD  = 1'b0;
            ptrD   = ptrQ + ADDR_W'(lenQ);
            countD = countQ + 16'd1;
        end else begin
            weD   = 1'b1;
            idxD  = 4'(byteIdx + 4'd1);
            addrD = ptrQ + ADDR_W'(idxD);
            dataD = byteMux;
        end
    end

    // Output and pointer registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            weQ     <= 1'b0;
            addrQ   <= BASE_ADDR;
            dataQ   <= 8'd0;
            readyQ  <= 1'b1;
            busyQ   <= 1'b0;
            errQ    <= 1'b0;
            ptrQ    <= BASE_ADDR;
            countQ  <= 16'd0;
            byteIdx <= 4'd0;
        end else begin
            weQ     <= weD;
            addrQ   <= addrD;
            dataQ   <= dataD;
            readyQ  <= readyD;
            busyQ   <= busyD;
            errQ    <= errD;
            ptrQ    <= ptrD;
            countQ  <= countD;
            byteIdx <= idxD;
        end
    end

    // Instruction field capture on accept.
    always_ff @(posedge clk_i) begin
        // NOTE: captured fields carry no reset; they are only read after an accept has loaded them.
        if (take) begin
            instQ <= inFields;
            lenQ  <= newLen;
        end
    end

    assign bus.in_ready_o   = readyQ;
    assign bus.mem_we_o     = weQ;
    assign bus.mem_addr_o   = addrQ;
    assign bus.mem_wdata_o  = dataQ;
    assign bus.wr_ptr_o     = ptrQ;
    assign bus.inst_count_o = countQ;
    assign bus.busy_o       = busyQ;
    assign bus.err_o        = errQ;

endmodule

// File: tb/tb_y86_inst_loader.sv
// Self-checking bench for y86_inst_loader with a small 16-byte memory to reach the bounds.
module tb_y86_inst_loader;

    localparam int MEM = 16;

    logic clk = 1'b0;
    logic rst;
    int   nChecks = 0;
    int   nPass   = 0;

    y86_inst_loader_if #(.ADDR_W(64)) bus ();

    y86_inst_loader #(
        .MEM_SIZE  (MEM),
        .ADDR_W    (64),
        .BASE_ADDR (64'd0)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model state.
    logic [63:0] mPtr;
    logic [15:0] mCount;

    // Observed writes, sampled mid-cycle.
    typedef struct {
        logic [63:0] addr;
        logic [7:0]  data;
    } wrRec;
    wrRec       wrQ[$];
    logic [7:0] ramObs [MEM];

    always @(negedge clk) begin
        if (bus.mem_we_o === 1'b1) begin
            wrQ.push_back('{bus.mem_addr_o, bus.mem_wdata_o});
            if (bus.mem_addr_o < 64'(MEM)) ramObs[bus.mem_addr_o[3:0]] = bus.mem_wdata_o;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    function automatic int lenOf(input logic [3:0] ic);
        case (ic)
            4'h0, 4'h1, 4'h9:       return 1;
            4'h2, 4'h6, 4'hA, 4'hB: return 2;
            4'h7, 4'h8:             return 9;
            4'h3, 4'h4, 4'h5:       return 10;
            default:                return 0;
        endcase
    endfunction

    // Build the byte image of one instruction straight from the encoding rules.
    task automatic encode(input logic [3:0] ic, fn, ra, rb, input logic [63:0] vc,
                          output logic [7:0] b [10], output int n);
        n = lenOf(ic);
        foreach (b[i]) b[i] = 8'h00;
        b[0] = {ic, fn};
        if (n == 2 || n == 10) b[1] = {ra, rb};
        if (n >= 9)
            for (int i = 0; i < 8; i++) b[i + n - 8] = 8'(vc >> (8 * i));
    endtask

    task automatic checkResetState(input string pfx);
        check({pfx, "_ready"}, bus.in_ready_o, 1);
        check({pfx, "_busy"},  bus.busy_o, 0);
        check({pfx, "_we"},    bus.mem_we_o, 0);
        check({pfx, "_addr"},  bus.mem_addr_o, 0);
        check({pfx, "_wdata"}, bus.mem_wdata_o, 0);
        check({pfx, "_ptr"},   bus.wr_ptr_o, 0);
        check({pfx, "_count"}, bus.inst_count_o, 0);
        check({pfx, "_err"},   bus.err_o, 0);
    endtask

    task automatic waitReady();
        for (int c = 0; c < 30 && bus.in_ready_o !== 1'b1; c++) @(negedge clk);
        check("ready_before_send", bus.in_ready_o, 1);
    endtask

    task automatic driveInst(input logic [3:0] ic, fn, ra, rb, input logic [63:0] vc);
        bus.icode_i    = ic;
        bus.ifun_i     = fn;
        bus.rA_i       = ra;
        bus.rB_i       = rb;
        bus.valC_i     = vc;
        bus.in_valid_i = 1'b1;
    endtask

    // Drop valid and scramble the fields: they are don't-care after accept.
    task automatic releaseInst();
        bus.in_valid_i = 1'b0;
        bus.icode_i    = 4'($urandom);
        bus.ifun_i     = 4'($urandom);
        bus.rA_i       = 4'($urandom);
        bus.rB_i       = 4'($urandom);
        bus.valC_i     = {$urandom, $urandom};
    endtask

    task automatic sendInst(input logic [3:0] ic, fn, ra, rb, input logic [63:0] vc);
        logic [7:0]  exp [10];
        int          n;
        int          low;
        bit          fitsM;
        bit          busyOk;
        logic [63:0] base;
        encode(ic, fn, ra, rb, vc, exp, n);
        fitsM = (n != 0) && (mPtr + 64'(n) <= 64'(MEM));
        base  = mPtr;
        waitReady();
        wrQ.delete();
        @(negedge clk);
        driveInst(ic, fn, ra, rb, vc);
        @(posedge clk);
        #1 releaseInst();
        if (!fitsM) begin
            @(negedge clk);
            check("err_pulse", bus.err_o, 1);
            check("ready_on_reject", bus.in_ready_o, 1);
            @(negedge clk);
            check("err_single", bus.err_o, 0);
            check("reject_no_write", wrQ.size(), 0);
            check("reject_ptr", bus.wr_ptr_o, mPtr);
            check("reject_count", bus.inst_count_o, mCount);
        end else begin
            low    = 0;
            busyOk = 1'b1;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                if (bus.in_ready_o === 1'b1) break;
                low++;
                if (bus.busy_o !== 1'b1 || bus.err_o !== 1'b0) busyOk = 1'b0;
            end
            check("emit_cycles", low, n);
            check("busy_during_emit", busyOk, 1);
            check("write_count", wrQ.size(), n);
            for (int k = 0; k < n && k < wrQ.size(); k++) begin
                check($sformatf("byte_addr[%0d]", k), wrQ[k].addr, base + 64'(k));
                check($sformatf("byte_data[%0d]", k), wrQ[k].data, exp[k]);
            end
            mPtr   = mPtr + 64'(n);
            mCount = mCount + 16'd1;
            check("wr_ptr", bus.wr_ptr_o, mPtr);
            check("inst_count", bus.inst_count_o, mCount);
            check("busy_after", bus.busy_o, 0);
        end
    endtask

    task automatic doRestart();
        @(negedge clk);
        bus.restart_i = 1'b1;
        @(posedge clk);
        #1 bus.restart_i = 1'b0;
        mPtr   = 64'd0;
        mCount = 16'd0;
        @(negedge clk);
        check("restart_ptr", bus.wr_ptr_o, 0);
        check("restart_count", bus.inst_count_o, 0);
        check("restart_ready", bus.in_ready_o, 1);
    endtask

    initial begin
        logic [7:0] g1 [10];
        logic [7:0] g2 [12];
        logic [7:0] e [10];
        int         n;
        logic [3:0] ic;

        g1 = '{8'h30, 8'hF2, 8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
        g2 = '{8'h00, 8'h60, 8'h03, 8'h70, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

        rst           = 1'b1;
        bus.restart_i = 1'b0;
        releaseInst();
        mPtr   = 64'd0;
        mCount = 16'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkResetState("reset");

        // irmovq $0x0123456789ABCDEF, %rdx
        sendInst(4'h3, 4'h0, 4'hF, 4'h2, 64'h0123456789ABCDEF);
        for (int i = 0; i < 10; i++) check($sformatf("ram_irmovq[%0d]", i), ramObs[i], g1[i]);

        // halt; addq %rax,%rbx; jmp 0x100 back to back
        doRestart();
        sendInst(4'h0, 4'h0, 4'hF, 4'hF, 64'd0);
        sendInst(4'h6, 4'h0, 4'h0, 4'h3, 64'd0);
        sendInst(4'h7, 4'h0, 4'hF, 4'hF, 64'h100);
        for (int i = 0; i < 12; i++) check($sformatf("ram_b2b[%0d]", i), ramObs[i], g2[i]);

        // Fill to 10, then an irmovq no longer fits but a pushq does
        doRestart();
        sendInst(4'h3, 4'h0, 4'hF, 4'h1, 64'h1122334455667788);
        sendInst(4'h3, 4'h0, 4'hF, 4'h2, 64'hDEADBEEF);
        sendInst(4'hA, 4'h0, 4'h0, 4'hF, 64'd0);
        check("ram_push0", ramObs[10], 8'hA0);
        check("ram_push1", ramObs[11], 8'h0F);

        // Invalid icode and bound cases at the top of memory
        sendInst(4'hC, 4'h0, 4'h1, 4'h2, 64'd5);
        sendInst(4'h5, 4'h0, 4'h1, 4'h2, 64'd8);
        sendInst(4'h8, 4'h0, 4'hF, 4'hF, 64'h40);
        sendInst(4'hA, 4'h0, 4'h1, 4'hF, 64'd0);
        sendInst(4'hB, 4'h0, 4'h3, 4'hF, 64'd0);
        sendInst(4'h0, 4'h0, 4'hF, 4'hF, 64'd0);
        sendInst(4'hF, 4'h0, 4'hF, 4'hF, 64'd0);

        // Restart during the fourth byte: only bytes 0..2 reach memory
        doRestart();
        encode(4'h3, 4'h0, 4'hF, 4'h2, 64'hCAFEF00D12345678, e, n);
        wrQ.delete();
        @(negedge clk);
        driveInst(4'h3, 4'h0, 4'hF, 4'h2, 64'hCAFEF00D12345678);
        @(posedge clk);
        #1 releaseInst();
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        bus.restart_i = 1'b1;
        @(posedge clk);
        #1 bus.restart_i = 1'b0;
        @(negedge clk);
        check("rs_we_low", bus.mem_we_o, 0);
        check("rs_ptr", bus.wr_ptr_o, 0);
        check("rs_count", bus.inst_count_o, 0);
        check("rs_ready", bus.in_ready_o, 1);
        check("rs_busy", bus.busy_o, 0);
        check("rs_bytes", wrQ.size(), 3);
        for (int k = 0; k < 3 && k < wrQ.size(); k++) begin
            check($sformatf("rs_addr[%0d]", k), wrQ[k].addr, 64'(k));
            check($sformatf("rs_data[%0d]", k), wrQ[k].data, e[k]);
        end
        mPtr   = 64'd0;
        mCount = 16'd0;

        // Reset in the middle of an emission
        sendInst(4'h1, 4'h0, 4'hF, 4'hF, 64'd0);
        @(negedge clk);
        driveInst(4'h4, 4'h0, 4'h1, 4'h2, 64'h18);
        @(posedge clk);
        #1 releaseInst();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkResetState("rst_mid");
        mPtr   = 64'd0;
        mCount = 16'd0;

        // Program image: irmovq then halt
        sendInst(4'h3, 4'h0, 4'hF, 4'h2, 64'h0123456789ABCDEF);
        sendInst(4'h0, 4'h0, 4'hF, 4'hF, 64'd0);
        for (int i = 0; i < 10; i++) check($sformatf("ram_prog[%0d]", i), ramObs[i], g1[i]);
        check("ram_prog_halt", ramObs[10], 8'h00);

        // Randomized stream against the model
        for (int t = 0; t < 80; t++) begin
            if (mPtr > 64'd6 && $urandom_range(0, 2) == 0) doRestart();
            if ($urandom_range(0, 7) == 0) ic = 4'($urandom_range(12, 15));
            else                           ic = 4'($urandom_range(0, 11));
            sendInst(ic, 4'($urandom), 4'($urandom), 4'($urandom), {$urandom, $urandom});
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
